// File: rtl/warp_ahb_sram_pkg.sv
// Shared AHB5 definitions: transfer/size/response codes, lane mask, alignment check.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package warp_ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_e;

  // NONSEQ/SEQ carry a transfer; IDLE/BUSY never do.
  function automatic logic is_xfer(input logic [1:0] htrans);
    logic r;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte lanes touched by a transfer of the given size at byte offset off.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      HSIZE_BYTE: m = 8'h01 << off;
      HSIZE_HALF: m = 8'h03 << {off[2:1], 1'b0};
      HSIZE_WORD: m = 8'h0F << {off[2], 2'b00};
      default:    m = 8'hFF;
    endcase
    return m;
  endfunction

  // Offset bits that must be zero for a naturally aligned transfer.
  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] off);
    logic [2:0] need_zero;
    need_zero = {size == HSIZE_DWORD, size >= HSIZE_WORD, size >= HSIZE_HALF};
    return (off & need_zero) != 3'b000;
  endfunction

endpackage

// File: rtl/warp_ahb_sram_sram_1rw.sv
// Byte-writable synchronous SRAM, 64-bit words, 2**DEPTH_LOG2 deep.
// Latency: read data appears one clock after i_re; write lands on the same edge.
// Backpressure: none; one read and one write may share an edge, read sees pre-write contents.
module warp_sram_1rw #(
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                  i_clk,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [7:0]            i_be,
  input  logic [63:0]           i_wdat,
  output logic [63:0]           o_rdat
);

  logic [63:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [63:0] r_q;

  // Array update per enabled byte lane, and registered read port (holds when idle).
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 8; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr][b*8 +: 8] <= i_wdat[b*8 +: 8];
      end
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdat = r_q;

endmodule

// File: rtl/warp_ahb_sram.sv
// AHB5 subordinate in front of a 64-bit byte-writable SRAM, with ERROR for bad addresses.
// Latency: WAIT_STATES stalled data-phase cycles, then completion; faults take two cycles.
// Backpressure: drives hreadyout low during waits/ERR1; accepts only when bus hready is high.
module warp_ahb_sram
  import warp_ahb_sram_pkg::*;
#(
  parameter int DEPTH_LOG2  = 13,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ahb_hsel,
  input  logic [33:0] i_ahb_haddr,
  input  logic [1:0]  i_ahb_htrans,
  input  logic [2:0]  i_ahb_hsize,
  input  logic [2:0]  i_ahb_hburst,
  input  logic        i_ahb_hwrite,
  input  logic [63:0] i_ahb_hwdata,
  input  logic [7:0]  i_ahb_hwstrb,
  input  logic        i_ahb_hready,
  output logic [63:0] o_ahb_hrdata,
  output logic        o_ahb_hreadyout,
  output logic        o_ahb_hresp,
  output logic        o_ahb_hexokay
);

  localparam int AW = DEPTH_LOG2;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb_state_e    r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_widx;
  logic [2:0]    r_boff;
  logic [2:0]    r_size;
  logic          r_write;

  logic          w_open, w_accept, w_fault;
  logic          w_rd_launch, w_wr_commit, w_rd_done;
  logic [AW-1:0] w_raddr;
  logic [7:0]    w_wr_be;
  logic [63:0]   w_sram_q, w_byp_bits, w_rd_live;

  logic          r_byp_vld;
  logic [7:0]    r_byp_be;
  logic [63:0]   r_byp_dat;
  logic [63:0]   r_hold;

  // Burst type is irrelevant: every beat carries its own address.
  logic w_unused_hburst;
  assign w_unused_hburst = ^i_ahb_hburst;

  // A new address phase can only be taken in a cycle where this block reports ready.
  assign w_open   = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept = w_open && i_ahb_hsel && i_ahb_hready && is_xfer(i_ahb_htrans);
  assign w_fault  = ((i_ahb_haddr >> (AW + 3)) != 34'd0) ||
                    misaligned(i_ahb_hsize, i_ahb_haddr[2:0]);

  // Write commits at the end of its DATA cycle; read launches on the edge just before DATA.
  assign w_wr_commit = (r_state == ST_DATA) && r_write;
  assign w_wr_be     = i_ahb_hwstrb & lane_mask(r_size, r_boff);
  assign w_rd_launch = (w_accept && !w_fault && !i_ahb_hwrite && (WAIT_STATES == 0)) ||
                       ((r_state == ST_WAIT) && (r_cnt == 4'd0) && !r_write);
  assign w_raddr     = (r_state == ST_WAIT) ? r_widx : i_ahb_haddr[AW+2:3];
  assign w_rd_done   = (r_state == ST_DATA) && !r_write;

  warp_sram_1rw #(.DEPTH_LOG2(AW)) u_sram (
    .i_clk   (i_clk),
    .i_re    (w_rd_launch),
    .i_raddr (w_raddr),
    .i_we    (w_wr_commit),
    .i_waddr (r_widx),
    .i_be    (w_wr_be),
    .i_wdat  (i_ahb_hwdata),
    .o_rdat  (w_sram_q)
  );

  // State and wait counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, wait countdown and response outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    o_ahb_hreadyout = 1'b1;
    o_ahb_hresp     = HRESP_OKAY;
    case (r_state)
      ST_WAIT: begin
        o_ahb_hreadyout = 1'b0;
        if (r_cnt == 4'd0) w_state_nxt = ST_DATA;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_ERR1: begin
        o_ahb_hreadyout = 1'b0;
        o_ahb_hresp     = HRESP_ERROR;
        w_state_nxt     = ST_ERR2;
      end
      ST_ERR2: begin
        o_ahb_hresp = HRESP_ERROR;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_accept) begin
      if (w_fault) begin
        w_state_nxt = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = WS_INIT;
      end else begin
        w_state_nxt = ST_DATA;
      end
    end
  end

  // Address-phase capture for the data phase that follows.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_widx  <= '0;
      r_boff  <= 3'd0;
      r_size  <= 3'd0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_widx  <= i_ahb_haddr[AW+2:3];
      r_boff  <= i_ahb_haddr[2:0];
      r_size  <= i_ahb_hsize;
      r_write <= i_ahb_hwrite;
    end
  end

  // A read launched on the same edge a write commits to that word sees stale array data;
  // remember the committed bytes so they can be merged into the returned word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byp_vld <= 1'b0;
      r_byp_be  <= 8'h00;
      r_byp_dat <= 64'd0;
    end else if (w_rd_launch) begin
      r_byp_vld <= w_wr_commit && (r_widx == w_raddr);
      r_byp_be  <= w_wr_be;
      r_byp_dat <= i_ahb_hwdata;
    end
  end

  // Byte-enable to bit-mask expansion for the bypass merge.
  always_comb begin
    w_byp_bits = 64'd0;
    for (int b = 0; b < 8; b++) begin
      w_byp_bits[b*8 +: 8] = {8{r_byp_be[b]}};
    end
  end

  assign w_rd_live = r_byp_vld ? ((w_sram_q & ~w_byp_bits) | (r_byp_dat & w_byp_bits))
                               : w_sram_q;

  // Read data holds between reads so the manager sees a stable bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_hold <= 64'd0;
    else if (w_rd_done) r_hold <= w_rd_live;
  end

  assign o_ahb_hrdata  = w_rd_done ? w_rd_live : r_hold;
  assign o_ahb_hexokay = 1'b0;

endmodule

// File: tb/tb_warp_ahb_sram.sv
// Bench for warp_ahb_sram: three instances (1, 0 and 3 wait states) on one shared bus.
// Latency: per-cycle response prediction from a transaction-level model.
// Backpressure: the driver behaves as an AHB manager and advances only on hready.
module tb_warp_ahb_sram;

  typedef struct packed {
    logic [1:0]  d;
    logic        rdy;
    logic        resp;
    logic        chk;
    logic [63:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [33:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic        force_lo;
  logic [2:0]  hready_in;
  logic [2:0]  rdyout, resp, exok;
  logic [63:0] rdata [3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  exp_t        expq[$];
  logic [63:0] mdl_mem [int];
  logic [63:0] mdl_hold [3];

  int          n_it;
  logic [1:0]  it_trans [16];
  logic [33:0] it_addr  [16];
  logic [2:0]  it_size  [16];
  logic        it_wr    [16];
  logic [63:0] it_dat   [16];
  logic [7:0]  it_strb  [16];

  always #5 clk = ~clk;

  assign hready_in = force_lo ? 3'b000 : rdyout;

  warp_ahb_sram #(.DEPTH_LOG2(13), .WAIT_STATES(1)) u_ws1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ahb_hsel(hsel[0]), .i_ahb_haddr(haddr),
    .i_ahb_htrans(htrans), .i_ahb_hsize(hsize), .i_ahb_hburst(hburst), .i_ahb_hwrite(hwrite),
    .i_ahb_hwdata(hwdata), .i_ahb_hwstrb(hwstrb), .i_ahb_hready(hready_in[0]),
    .o_ahb_hrdata(rdata[0]), .o_ahb_hreadyout(rdyout[0]), .o_ahb_hresp(resp[0]),
    .o_ahb_hexokay(exok[0]));

  warp_ahb_sram #(.DEPTH_LOG2(13), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ahb_hsel(hsel[1]), .i_ahb_haddr(haddr),
    .i_ahb_htrans(htrans), .i_ahb_hsize(hsize), .i_ahb_hburst(hburst), .i_ahb_hwrite(hwrite),
    .i_ahb_hwdata(hwdata), .i_ahb_hwstrb(hwstrb), .i_ahb_hready(hready_in[1]),
    .o_ahb_hrdata(rdata[1]), .o_ahb_hreadyout(rdyout[1]), .o_ahb_hresp(resp[1]),
    .o_ahb_hexokay(exok[1]));

  warp_ahb_sram #(.DEPTH_LOG2(13), .WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ahb_hsel(hsel[2]), .i_ahb_haddr(haddr),
    .i_ahb_htrans(htrans), .i_ahb_hsize(hsize), .i_ahb_hburst(hburst), .i_ahb_hwrite(hwrite),
    .i_ahb_hwdata(hwdata), .i_ahb_hwstrb(hwstrb), .i_ahb_hready(hready_in[2]),
    .o_ahb_hrdata(rdata[2]), .o_ahb_hreadyout(rdyout[2]), .o_ahb_hresp(resp[2]),
    .o_ahb_hexokay(exok[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: memory per instance, responses per transfer ----------------
  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  function automatic bit m_fault(input logic [33:0] a, input logic [2:0] sz);
    return (a >= 34'h10000) || ((a % (34'd1 << sz)) != 34'd0);
  endfunction

  function automatic int m_key(input int d, input logic [33:0] a);
    return d * 65536 + int'(a[15:3]);
  endfunction

  task automatic m_write(input int d, input int i);
    int k;
    int off;
    int len;
    logic [63:0] w;
    k   = m_key(d, it_addr[i]);
    w   = mdl_mem.exists(k) ? mdl_mem[k] : 64'hx;
    off = int'(it_addr[i][2:0]);
    len = 1 << it_size[i];
    for (int b = 0; b < 8; b++) begin
      if (b >= off && b < off + len && it_strb[i][b]) w[b*8 +: 8] = it_dat[i][b*8 +: 8];
    end
    mdl_mem[k] = w;
  endtask

  task automatic m_accept(input int d, input int i);
    exp_t e;
    e.d = 2'(d); e.chk = 1'b0; e.dat = 64'd0;
    if (!it_trans[i][1]) begin
      e.rdy = 1'b1; e.resp = 1'b0; expq.push_back(e);
    end else if (m_fault(it_addr[i], it_size[i])) begin
      e.rdy = 1'b0; e.resp = 1'b1; expq.push_back(e);
      e.rdy = 1'b1; expq.push_back(e);
    end else begin
      e.rdy = 1'b0; e.resp = 1'b0;
      for (int w = 0; w < ws_of(d); w++) expq.push_back(e);
      e.rdy = 1'b1;
      if (!it_wr[i]) begin
        e.chk = 1'b1;
        e.dat = mdl_mem[m_key(d, it_addr[i])];
      end
      expq.push_back(e);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : cmp
    exp_t e;
    int ed;
    logic xr, xs;
    logic [63:0] xd;
    if (cmp_en) begin
      ed = -1;
      e  = '0;
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        ed = int'(e.d);
      end
      for (int d = 0; d < 3; d++) begin
        if (d == ed) begin
          xr = e.rdy; xs = e.resp; xd = e.chk ? e.dat : mdl_hold[d];
        end else begin
          xr = 1'b1; xs = 1'b0; xd = mdl_hold[d];
        end
        chk($sformatf("hreadyout[%0d]", d), 64'(rdyout[d]), 64'(xr));
        chk($sformatf("hresp[%0d]", d), 64'(resp[d]), 64'(xs));
        chk($sformatf("hrdata[%0d]", d), rdata[d], xd);
        if (d == ed && e.chk) mdl_hold[d] = e.dat;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    n_it = 0;
  endtask

  task automatic add(input logic [1:0] tr, input logic [33:0] a, input logic [2:0] sz,
                     input logic wr, input logic [63:0] dat, input logic [7:0] strb);
    it_trans[n_it] = tr; it_addr[n_it] = a; it_size[n_it] = sz;
    it_wr[n_it] = wr; it_dat[n_it] = dat; it_strb[n_it] = strb;
    n_it++;
  endtask

  task automatic bus_idle();
    hsel = 3'b000; htrans = 2'b00; haddr = 34'd0; hsize = 3'd0;
    hwrite = 1'b0; hwdata = 64'd0; hwstrb = 8'h00;
  endtask

  // Pipelined AHB manager: entered and left 1 time unit after a rising edge.
  task automatic run_seq(input int d, output int stalls);
    int  idx = 0;
    int  dp = -1;
    int  guard = 0;
    bit  rdy;
    stalls = 0;
    while ((idx < n_it || dp >= 0) && guard < 200) begin
      if (idx < n_it) begin
        hsel = 3'(1 << d); htrans = it_trans[idx]; haddr = it_addr[idx];
        hsize = it_size[idx]; hwrite = it_wr[idx];
      end else begin
        hsel = 3'b000; htrans = 2'b00;
      end
      hwdata = (dp >= 0) ? it_dat[dp] : 64'd0;
      hwstrb = (dp >= 0) ? it_strb[dp] : 8'h00;
      @(negedge clk);
      rdy = rdyout[d];
      if (!rdy) stalls++;
      @(posedge clk);
      if (rdy) begin
        if (dp >= 0 && it_wr[dp] && !m_fault(it_addr[dp], it_size[dp])) m_write(d, dp);
        dp = -1;
        if (idx < n_it) begin
          m_accept(d, idx);
          if (it_trans[idx][1]) dp = idx;
          idx++;
        end
      end
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL run_seq_timeout dut=%0d actual=%0d required<200 cycles", d, guard);
    end
    bus_idle();
  endtask

  initial begin
    int st;
    bus_idle();
    hburst   = 3'b000;
    force_lo = 1'b0;
    rst_n    = 1'b0;
    for (int d = 0; d < 3; d++) mdl_hold[d] = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_hreadyout[%0d]", d), 64'(rdyout[d]), 64'd1);
      chk($sformatf("reset_hresp[%0d]", d), 64'(resp[d]), 64'd0);
      chk($sformatf("reset_hrdata[%0d]", d), rdata[d], 64'd0);
      chk($sformatf("hexokay[%0d]", d), 64'(exok[d]), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // 1: doubleword write then read, one wait state
    clr();
    add(2'b10, 34'h040, 3'd3, 1'b1, 64'h1122334455667788, 8'hFF);
    add(2'b10, 34'h040, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(0, st);
    chk("t1_stalls", 64'(st), 64'd2);
    chk("t1_rdata", rdata[0], 64'h1122334455667788);

    // 2: byte write to lane 3 with all strobes set
    clr();
    add(2'b10, 34'h043, 3'd0, 1'b1, 64'h00000000AB000000, 8'hFF);
    add(2'b10, 34'h040, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(0, st);
    chk("t2_rdata", rdata[0], 64'h11223344AB667788);

    // 3: zero-wait write immediately followed by read of the same word
    clr();
    add(2'b10, 34'h048, 3'd3, 1'b1, 64'hDEADBEEFCAFEF00D, 8'hFF);
    add(2'b10, 34'h048, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(1, st);
    chk("t3_stalls", 64'(st), 64'd0);
    chk("t3_rdata", rdata[1], 64'hDEADBEEFCAFEF00D);

    // 3b: partial-byte bypass
    clr();
    add(2'b10, 34'h049, 3'd0, 1'b1, 64'h000000000000AA00, 8'hFF);
    add(2'b11, 34'h048, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(1, st);
    chk("t3b_rdata", rdata[1], 64'hDEADBEEFCAFEAA0D);

    // 4: out-of-range read, misaligned word read, misaligned half write, then readback
    clr();
    add(2'b10, 34'h0_0001_0000, 3'd3, 1'b0, 64'd0, 8'h00);
    add(2'b10, 34'h002, 3'd2, 1'b0, 64'd0, 8'h00);
    add(2'b10, 34'h041, 3'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    add(2'b10, 34'h040, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(0, st);
    chk("t4_stalls", 64'(st), 64'd4);
    chk("t4_rdata", rdata[0], 64'h11223344AB667788);

    // 5: IDLE and BUSY with hsel set, then a normal read
    clr();
    add(2'b00, 34'h040, 3'd3, 1'b1, 64'd0, 8'hFF);
    add(2'b01, 34'h040, 3'd3, 1'b1, 64'd0, 8'hFF);
    add(2'b10, 34'h040, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(0, st);
    chk("t5_stalls", 64'(st), 64'd1);

    // bus hready low from another subordinate: request must not be taken
    force_lo = 1'b1;
    hsel = 3'b001; htrans = 2'b10; haddr = 34'h040; hsize = 3'd3; hwrite = 1'b1;
    @(posedge clk); #1;
    force_lo = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;

    // 6: three wait states; establish old contents, then reset during a write's WAIT
    clr();
    add(2'b10, 34'h050, 3'd3, 1'b1, 64'h5555AAAA5555AAAA, 8'hFF);
    add(2'b10, 34'h050, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(2, st);
    chk("t6_stalls", 64'(st), 64'd6);
    chk("t6_old", rdata[2], 64'h5555AAAA5555AAAA);

    cmp_en = 1'b0;
    expq.delete();
    hsel = 3'b100; htrans = 2'b10; haddr = 34'h050; hsize = 3'd3; hwrite = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 64'h0123456789ABCDEF; hwstrb = 8'hFF;
    @(posedge clk); #1;
    chk("t6_in_wait", 64'(rdyout[2]), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_hreadyout", 64'(rdyout[2]), 64'd1);
    chk("t6_rst_hresp", 64'(resp[2]), 64'd0);
    chk("t6_rst_hrdata", rdata[2], 64'd0);
    bus_idle();
    @(negedge clk) rst_n = 1'b1;
    for (int d = 0; d < 3; d++) mdl_hold[d] = 64'd0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    clr();
    add(2'b10, 34'h050, 3'd3, 1'b0, 64'd0, 8'h00);
    run_seq(2, st);
    chk("t6_after_rst", rdata[2], 64'h5555AAAA5555AAAA);

    repeat (2) @(posedge clk);
    #1;
    chk("model_queue_drained", 64'(expq.size()), 64'd0);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
